// File: rtl/mu0_pkg.sv
// Shared MU0 control definitions: state encoding, opcodes, ALU function codes and
// the bundle of datapath control signals driven by the control unit.
package mu0_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_INC    = 2'b11;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fs;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic       rd;
    logic       wr;
  } ctrl_t;

  // PC <= IR[11:0]: pass the zero-extended operand through the ALU.
  function automatic ctrl_t jump_ctrl();
    ctrl_t c;
    c        = '0;
    c.y_sel  = 1'b1;
    c.alu_fs = ALU_PASS_Y;
    c.pc_en  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational EXEC-cycle decoder: opcode and ACC flags to datapath controls.
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       n_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_LDA: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.rd       = 1'b1;
        ctrl_o.alu_fs   = ALU_PASS_Y;
        ctrl_o.acc_en   = 1'b1;
      end
      OP_STA: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.wr       = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl_o.addr_sel = 1'b1;
        ctrl_o.rd       = 1'b1;
        ctrl_o.alu_fs   = (opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
        ctrl_o.acc_en   = 1'b1;
      end
      OP_JMP: ctrl_o = jump_ctrl();
      OP_JGE: if (!n_i) ctrl_o = jump_ctrl();
      OP_JNE: if (!z_i) ctrl_o = jump_ctrl();
      OP_STP: ctrl_o = '0;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencing with memory wait states and
// synchronous reset forcing of all enables and strobes.
module mu0_control
  import mu0_pkg::*;
#(
  parameter int unsigned USE_MEMRDY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Opcode,
  input  logic       N,
  input  logic       Z,
  input  logic       MemRdy,
  output logic       X_sel,
  output logic       Y_sel,
  output logic       Addr_sel,
  output logic [1:0] ALU_fs,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic       Fetch
);

  state_e state_q, state_d;
  ctrl_t  exec_ctrl, ctrl;
  logic   halted;

  mu0_decode u_decode (
    .opcode_i (Opcode),
    .n_i      (N),
    .z_i      (Z),
    .ctrl_o   (exec_ctrl)
  );

  always_comb begin
    ctrl    = '0;
    halted  = 1'b0;
    state_d = state_q;
    case (state_q)
      StFetch: begin
        ctrl.addr_sel = 1'b0;
        ctrl.rd       = 1'b1;
        ctrl.ir_en    = 1'b1;
        ctrl.x_sel    = 1'b1;
        ctrl.alu_fs   = ALU_INC;
        ctrl.pc_en    = 1'b1;
        state_d       = StExec;
      end
      StExec: begin
        ctrl    = exec_ctrl;
        state_d = (Opcode == OP_STP) ? StHalt : StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase

    // Memory not ready: keep strobes and address, freeze registers and state.
    if ((USE_MEMRDY != 0) && (ctrl.rd || ctrl.wr) && !MemRdy) begin
      ctrl.pc_en  = 1'b0;
      ctrl.ir_en  = 1'b0;
      ctrl.acc_en = 1'b0;
      state_d     = state_q;
    end

    if (Reset) begin
      ctrl.pc_en  = 1'b0;
      ctrl.ir_en  = 1'b0;
      ctrl.acc_en = 1'b0;
      ctrl.rd     = 1'b0;
      ctrl.wr     = 1'b0;
      halted      = 1'b0;
      state_d     = StFetch;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign X_sel    = ctrl.x_sel;
  assign Y_sel    = ctrl.y_sel;
  assign Addr_sel = ctrl.addr_sel;
  assign ALU_fs   = ctrl.alu_fs;
  assign PC_En    = ctrl.pc_en;
  assign IR_En    = ctrl.ir_en;
  assign Acc_En   = ctrl.acc_en;
  assign Rd       = ctrl.rd;
  assign Wr       = ctrl.wr;
  assign Halted   = halted;
  assign Fetch    = (state_q == StFetch);

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed scenarios plus random stimulus
// against an instruction-level reference model.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Opcode = 4'd0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       MemRdy = 1'b1;
  logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted, Fetch;
  logic [1:0] ALU_fs;

  always #5 Clk = ~Clk;

  mu0_control #(.USE_MEMRDY(1)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Opcode   (Opcode),
    .N        (N),
    .Z        (Z),
    .MemRdy   (MemRdy),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .Addr_sel (Addr_sel),
    .ALU_fs   (ALU_fs),
    .PC_En    (PC_En),
    .IR_En    (IR_En),
    .Acc_En   (Acc_En),
    .Rd       (Rd),
    .Wr       (Wr),
    .Halted   (Halted),
    .Fetch    (Fetch)
  );

  // Observed vector layout.
  localparam int B_FETCH = 11, B_HALT = 10, B_X = 9, B_Y = 8, B_ADDR = 7, B_FS = 5;
  localparam int B_PC = 4, B_IR = 3, B_ACC = 2, B_RD = 1, B_WR = 0;

  logic [11:0] obs;
  assign obs = {Fetch, Halted, X_sel, Y_sel, Addr_sel, ALU_fs, PC_En, IR_En, Acc_En, Rd, Wr};

  int n_checks = 0;
  int n_fail = 0;

  // Model phase: 0 fetch, 1 execute, 2 halted, 3 unknown (before first reset).
  int          phase = 3;
  logic        l_rst = 1'b0;
  logic [3:0]  l_op = 4'd0;
  logic        l_rdy = 1'b1;
  logic [11:0] exp_v, exp_m;

  function automatic bit mem_phase(input int p, input logic [3:0] op);
    return (p == 0) || (p == 1 && op <= 4'd3);
  endfunction

  function automatic int next_phase(input int p, input logic rst, input logic [3:0] op,
                                    input logic rdy);
    if (rst) return 0;
    if (p == 3 || p == 2) return p;
    if (mem_phase(p, op) && !rdy) return p;
    if (p == 0) return 1;
    return (op == 4'd7) ? 2 : 0;
  endfunction

  function automatic void model(input int p, input logic rst, input logic [3:0] op,
                                input logic n, input logic z, input logic rdy,
                                output logic [11:0] v, output logic [11:0] m);
    v = '0;
    m = '1;
    case (p)
      0: begin
        v[B_FETCH] = 1'b1; v[B_X] = 1'b1; v[B_FS+:2] = 2'b11;
        v[B_PC] = 1'b1; v[B_IR] = 1'b1; v[B_RD] = 1'b1;
      end
      1: begin
        if (op == 4'd0 || op == 4'd2 || op == 4'd3) begin
          v[B_ADDR] = 1'b1; v[B_RD] = 1'b1; v[B_ACC] = 1'b1;
          v[B_FS+:2] = (op == 4'd0) ? 2'b00 : (op == 4'd2) ? 2'b01 : 2'b10;
        end else if (op == 4'd1) begin
          v[B_ADDR] = 1'b1; v[B_WR] = 1'b1;
        end else if (op == 4'd4 || (op == 4'd5 && !n) || (op == 4'd6 && !z)) begin
          v[B_Y] = 1'b1; v[B_PC] = 1'b1;
        end
      end
      2: begin
        v[B_HALT] = 1'b1;
        m[9:5] = '0;
      end
      default: m = '0;
    endcase
    if ((v[B_RD] || v[B_WR]) && !rdy) begin
      v[B_PC] = 1'b0; v[B_IR] = 1'b0; v[B_ACC] = 1'b0;
    end
    if (rst) begin
      v[B_PC] = 1'b0; v[B_IR] = 1'b0; v[B_ACC] = 1'b0;
      v[B_RD] = 1'b0; v[B_WR] = 1'b0; v[B_HALT] = 1'b0;
      m[B_PC] = 1'b1; m[B_IR] = 1'b1; m[B_ACC] = 1'b1;
      m[B_RD] = 1'b1; m[B_WR] = 1'b1; m[B_HALT] = 1'b1;
      m[9:5] = '0;
    end
  endfunction

  // Advance one clock, apply inputs, and leave expectations for the negedge sample.
  task automatic tick(input logic rst, input logic [3:0] op, input logic n, input logic z,
                      input logic rdy);
    @(posedge Clk);
    phase = next_phase(phase, l_rst, l_op, l_rdy);
    #1;
    Reset = rst; Opcode = op; N = n; Z = z; MemRdy = rdy;
    l_rst = rst; l_op = op; l_rdy = rdy;
    model(phase, rst, op, n, z, rdy, exp_v, exp_m);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ((obs & exp_m) !== (exp_v & exp_m)) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b expected %b mask %b", i, obs, exp_v, exp_m);
      end
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== 12'b1_0_1_0_0_11_1_1_0_1_0) begin
      n_fail++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, 12'b1_0_1_0_0_11_1_1_0_1_0);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0] ops [3] = '{4'd0, 4'd2, 4'd3};
    tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    foreach (ops[k]) begin
      for (int c = 0; c < 2; c++) begin
        tick(1'b0, ops[k], 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ((obs & exp_m) !== (exp_v & exp_m)) begin
          n_fail++;
          $display("FAIL alu_op%0d_cyc%0d: got %b expected %b", ops[k], c, obs, exp_v);
        end
      end
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (Fetch !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_back_to_fetch: got Fetch=%b expected 1", Fetch);
    end
  endtask

  task automatic test_jumps();
    logic [5:0] cases [5] = '{{4'd5, 2'b10}, {4'd5, 2'b00}, {4'd6, 2'b01},
                              {4'd6, 2'b00}, {4'd4, 2'b11}};
    tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    foreach (cases[k]) begin
      for (int c = 0; c < 2; c++) begin
        tick(1'b0, cases[k][5:2], cases[k][1], cases[k][0], 1'b0);
        n_checks++;
        if ((obs & exp_m) !== (exp_v & exp_m)) begin
          n_fail++;
          $display("FAIL jump_op%0d_nz%b_cyc%0d: got %b expected %b", cases[k][5:2],
                   cases[k][1:0], c, obs, exp_v);
        end
        // Fetch with MemRdy=0 stalls; release it so the next tick executes.
        if (c == 0) begin
          tick(1'b0, cases[k][5:2], cases[k][1], cases[k][0], 1'b1);
          n_checks++;
          if ((obs & exp_m) !== (exp_v & exp_m)) begin
            n_fail++;
            $display("FAIL jump_fetch_release: got %b expected %b", obs, exp_v);
          end
        end
      end
    end
  endtask

  task automatic test_sta_wait();
    int wr_cycles = 0;
    tick(1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 4'd1, 1'b0, 1'b0, (c == 3));
      if (Wr === 1'b1) wr_cycles++;
      n_checks++;
      if ((obs & exp_m) !== (exp_v & exp_m)) begin
        n_fail++;
        $display("FAIL sta_wait_cyc%0d: got %b expected %b", c, obs, exp_v);
      end
    end
    n_checks++;
    if (wr_cycles !== 4) begin
      n_fail++;
      $display("FAIL sta_wr_cycles: got %0d expected 4", wr_cycles);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (Fetch !== 1'b1 || Wr !== 1'b0) begin
      n_fail++;
      $display("FAIL sta_then_fetch: got Fetch=%b Wr=%b expected 1 0", Fetch, Wr);
    end
  endtask

  task automatic test_halt();
    tick(1'b1, 4'd7, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 4'd7, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick(1'b0, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)));
      n_checks++;
      if ((obs & exp_m) !== (exp_v & exp_m)) begin
        n_fail++;
        $display("FAIL halt_cyc%0d: got %b expected %b mask %b", c, obs, exp_v, exp_m);
      end
    end
    tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (Fetch !== 1'b1 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset_exit: got Fetch=%b Halted=%b expected 1 0", Fetch, Halted);
    end
  endtask

  task automatic test_nop_reset();
    tick(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 4'd9, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if ((obs & exp_m) !== (exp_v & exp_m)) begin
        n_fail++;
        $display("FAIL nop_cyc%0d: got %b expected %b", c, obs, exp_v);
      end
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (IR_En !== 1'b0 || Rd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_stall: got IR_En=%b Rd=%b expected 0 0", IR_En, Rd);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ((obs & exp_m) !== (exp_v & exp_m)) begin
      n_fail++;
      $display("FAIL after_stall_reset: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(31) == 0), 4'($urandom_range(15)), 1'($urandom_range(1)),
           1'($urandom_range(1)), ($urandom_range(3) != 0));
      n_checks++;
      if ((obs & exp_m) !== (exp_v & exp_m)) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %b expected %b mask %b", c, obs, exp_v, exp_m);
      end
      // Keep the random run from spending most of its time halted.
      if (phase == 2 && $urandom_range(7) == 0) begin
        tick(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_jumps();
    test_sta_wait();
    test_halt();
    test_nop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
